// File: rtl/kf8288_pkg.sv
// Shared status codes, cycle/state enums and the command decode for the KF8288 bus controller.
// Pure types and functions; no latency or flow-control behaviour of its own.
package KF8288_PKG;

  localparam logic [2:0] STS_INTA    = 3'b000;
  localparam logic [2:0] STS_IOR     = 3'b001;
  localparam logic [2:0] STS_IOW     = 3'b010;
  localparam logic [2:0] STS_HALT    = 3'b011;
  localparam logic [2:0] STS_FETCH   = 3'b100;
  localparam logic [2:0] STS_MEMR    = 3'b101;
  localparam logic [2:0] STS_MEMW    = 3'b110;
  localparam logic [2:0] STS_PASSIVE = 3'b111;

  typedef enum logic [2:0] {
    CT_INTA    = STS_INTA,
    CT_IOR     = STS_IOR,
    CT_IOW     = STS_IOW,
    CT_HALT    = STS_HALT,
    CT_FETCH   = STS_FETCH,
    CT_MEMR    = STS_MEMR,
    CT_MEMW    = STS_MEMW,
    CT_PASSIVE = STS_PASSIVE
  } cycle_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4
  } state_t;

  // Active-high internal view of the seven command strobes.
  typedef struct packed {
    logic mrdc;
    logic mwtc;
    logic amwc;
    logic iorc;
    logic iowc;
    logic aiowc;
    logic inta;
  } cmd_t;

  function automatic logic is_read(cycle_t ct);
    return ct inside {CT_INTA, CT_IOR, CT_FETCH, CT_MEMR};
  endfunction

  function automatic logic is_write(cycle_t ct);
    return ct inside {CT_IOW, CT_MEMW};
  endfunction

  // Read and advanced-write strobes span T2..T3; normal writes only T3.
  function automatic cmd_t decode_cmd(state_t st, cycle_t ct);
    cmd_t c;
    logic t23;
    logic t3;
    t23    = st inside {ST_T2, ST_T3};
    t3     = (st == ST_T3);
    c      = '0;
    c.mrdc  = t23 && (ct inside {CT_FETCH, CT_MEMR});
    c.iorc  = t23 && (ct == CT_IOR);
    c.inta  = t23 && (ct == CT_INTA);
    c.amwc  = t23 && (ct == CT_MEMW);
    c.aiowc = t23 && (ct == CT_IOW);
    c.mwtc  = t3  && (ct == CT_MEMW);
    c.iowc  = t3  && (ct == CT_IOW);
    return c;
  endfunction

endpackage

// File: rtl/kf8288.sv
// KF8288 bus controller: decodes CPU status into ALE/DEN/DT-R and command strobes via IDLE/T1..T4.
// Outputs registered one edge after status is sampled; AEN high or command_enable low forces commands off at once.
module kf8288
  import KF8288_PKG::*;
#(
  parameter int COMMAND_ENABLE_DELAY = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] processor_status_n,
  input  logic       address_enable_n,
  input  logic       command_enable,
  output logic       address_latch_enable,
  output logic       data_enable,
  output logic       data_transmit_receive_n,
  output logic       memory_read_command_n,
  output logic       memory_write_command_n,
  output logic       advanced_memory_write_command_n,
  output logic       io_read_command_n,
  output logic       io_write_command_n,
  output logic       advanced_io_write_command_n,
  output logic       interrupt_acknowledge_n
);

  localparam int CW = (COMMAND_ENABLE_DELAY < 1) ? 1 : $clog2(COMMAND_ENABLE_DELAY + 1);
  localparam logic [CW-1:0] DLY = CW'(COMMAND_ENABLE_DELAY);

  state_t        r_state;
  state_t        w_next_state;
  cycle_t        r_cycle_type;
  cycle_t        w_next_cycle_type;
  cycle_t        w_status;
  logic [CW-1:0] r_en_cnt;
  cmd_t          r_cmd;
  cmd_t          w_cmd;
  logic          r_ale;
  logic          w_ale;
  logic          r_den;
  logic          w_den;
  logic          r_dtr_n;
  logic          w_dtr_n;
  logic          w_cmd_ok;

  assign w_status = cycle_t'(processor_status_n);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cycle_type <= CT_PASSIVE;
      r_en_cnt     <= '0;
      r_cmd        <= '0;
      r_ale        <= 1'b0;
      r_den        <= 1'b0;
      r_dtr_n      <= 1'b1;
    end else begin
      r_state      <= w_next_state;
      r_cycle_type <= w_next_cycle_type;
      r_cmd        <= w_cmd;
      r_ale        <= w_ale;
      r_den        <= w_den;
      r_dtr_n      <= w_dtr_n;
      if (address_enable_n) begin
        r_en_cnt <= '0;
      end else if (r_en_cnt < DLY) begin
        r_en_cnt <= r_en_cnt + CW'(1);
      end
    end
  end

  // Cycle type is captured only on leaving IDLE; mid-cycle status changes matter only as PASSIVE in T3.
  always_comb begin
    w_next_state      = r_state;
    w_next_cycle_type = r_cycle_type;
    case (r_state)
      ST_IDLE: begin
        if (w_status != CT_PASSIVE) begin
          w_next_state      = ST_T1;
          w_next_cycle_type = w_status;
        end
      end
      ST_T1:   w_next_state = ST_T2;
      ST_T2:   w_next_state = ST_T3;
      ST_T3:   if (w_status == CT_PASSIVE) w_next_state = ST_T4;
      ST_T4:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Decode against the next state so the registered outputs line up with the state they describe.
  always_comb begin
    w_cmd   = decode_cmd(w_next_state, w_next_cycle_type);
    w_ale   = (w_next_state == ST_T1);
    w_dtr_n = !(is_read(w_next_cycle_type) && (w_next_state != ST_IDLE));
    w_den   = (is_read(w_next_cycle_type) && (w_next_state inside {ST_T2, ST_T3})) ||
              (is_write(w_next_cycle_type) && (w_next_state == ST_T3));
  end

  assign w_cmd_ok = command_enable && !address_enable_n && (r_en_cnt >= DLY);

  assign address_latch_enable            = r_ale;
  assign data_transmit_receive_n         = r_dtr_n;
  assign data_enable                     = r_den && command_enable;
  assign memory_read_command_n           = !(r_cmd.mrdc  && w_cmd_ok);
  assign memory_write_command_n          = !(r_cmd.mwtc  && w_cmd_ok);
  assign advanced_memory_write_command_n = !(r_cmd.amwc  && w_cmd_ok);
  assign io_read_command_n               = !(r_cmd.iorc  && w_cmd_ok);
  assign io_write_command_n              = !(r_cmd.iowc  && w_cmd_ok);
  assign advanced_io_write_command_n     = !(r_cmd.aiowc && w_cmd_ok);
  assign interrupt_acknowledge_n         = !(r_cmd.inta  && w_cmd_ok);

endmodule

// File: tb/tb_kf8288.sv
// Bench for kf8288: directed bus cycles with literal tallies, then randomized traffic against a phase-number model.
module tb_kf8288;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] status;
  logic       aen_n;
  logic       cen;
  logic       ale, den, dtr_n;
  logic       mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n;

  kf8288 #(.COMMAND_ENABLE_DELAY(2)) dut (
    .clock                           (clock),
    .reset_n                         (reset_n),
    .processor_status_n              (status),
    .address_enable_n                (aen_n),
    .command_enable                  (cen),
    .address_latch_enable            (ale),
    .data_enable                     (den),
    .data_transmit_receive_n         (dtr_n),
    .memory_read_command_n           (mrdc_n),
    .memory_write_command_n          (mwtc_n),
    .advanced_memory_write_command_n (amwc_n),
    .io_read_command_n               (iorc_n),
    .io_write_command_n              (iowc_n),
    .advanced_io_write_command_n     (aiowc_n),
    .interrupt_acknowledge_n         (inta_n)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = idle, 1..4 = bus T-state number; run = consecutive AEN-low edges.
  int m_phase = 0;
  int m_ct    = 7;
  int m_run   = 0;

  int n_ale, n_mrd, n_dtr_low, n_aiow, n_iow, n_den, n_inta, n_anycmd;
  int n_inta_pulse, n_inta_after_ale;
  bit ale_arm;
  logic prev_inta = 1'b1;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cmd_vec();
    return int'({mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n});
  endfunction

  task automatic clear_tallies();
    n_ale = 0; n_mrd = 0; n_dtr_low = 0; n_aiow = 0; n_iow = 0; n_den = 0;
    n_inta = 0; n_anycmd = 0; n_inta_pulse = 0; n_inta_after_ale = 0; ale_arm = 0;
  endtask

  // Compare process: advance the model on each rising edge, then check every output.
  always @(posedge clock) begin
    bit rd, wr, mid, late, ok;
    if (!reset_n) begin
      m_phase = 0;
      m_ct    = 7;
      m_run   = 0;
    end else begin
      m_run = aen_n ? 0 : ((m_run < 1000) ? m_run + 1 : m_run);
      case (m_phase)
        0: if (status != 3'd7) begin m_ct = int'(status); m_phase = 1; end
        1: m_phase = 2;
        2: m_phase = 3;
        3: if (status == 3'd7) m_phase = 4;
        default: m_phase = 0;
      endcase
    end
    #1;
    rd   = m_ct inside {0, 1, 4, 5};
    wr   = m_ct inside {2, 6};
    mid  = (m_phase == 2) || (m_phase == 3);
    late = (m_phase == 3);
    ok   = cen && !aen_n && (m_run >= 2);
    chk_b("ale",    ale,     m_phase == 1);
    chk_b("dtr_n",  dtr_n,   !(rd && m_phase != 0));
    chk_b("den",    den,     cen && ((rd && mid) || (wr && late)));
    chk_b("mrdc_n", mrdc_n,  !(ok && mid  && (m_ct == 4 || m_ct == 5)));
    chk_b("iorc_n", iorc_n,  !(ok && mid  && m_ct == 1));
    chk_b("inta_n", inta_n,  !(ok && mid  && m_ct == 0));
    chk_b("amwc_n", amwc_n,  !(ok && mid  && m_ct == 6));
    chk_b("aiow_n", aiowc_n, !(ok && mid  && m_ct == 2));
    chk_b("mwtc_n", mwtc_n,  !(ok && late && m_ct == 6));
    chk_b("iowc_n", iowc_n,  !(ok && late && m_ct == 2));
    if (ale) begin n_ale++; ale_arm = 1; end
    if (!mrdc_n)  n_mrd++;
    if (!dtr_n)   n_dtr_low++;
    if (!aiowc_n) n_aiow++;
    if (!iowc_n)  n_iow++;
    if (den)      n_den++;
    if (!inta_n)  n_inta++;
    if (cmd_vec() != 127) n_anycmd++;
    if (prev_inta && !inta_n) begin
      n_inta_pulse++;
      if (ale_arm) n_inta_after_ale++;
      ale_arm = 0;
    end
    prev_inta = inta_n;
  end

  task automatic step(input logic [2:0] s, input int n);
    repeat (n) begin
      @(negedge clock);
      status = s;
      aen_n  = 1'b0;
      cen    = 1'b1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    status  = 3'd7;
    aen_n   = 1'b0;
    cen     = 1'b1;
    clear_tallies();
    repeat (3) @(negedge clock);
    chk_i("reset_cmds",  cmd_vec(), 127);
    chk_b("reset_ale",   ale, 1'b0);
    chk_b("reset_den",   den, 1'b0);
    chk_b("reset_dtr_n", dtr_n, 1'b1);
    reset_n = 1'b1;
    step(3'd7, 4);

    // MEMR with two wait states
    clear_tallies();
    step(3'd5, 5);
    step(3'd7, 4);
    chk_i("memr_ale_cycles", n_ale, 1);
    chk_i("memr_mrdc_cycles", n_mrd, 4);
    chk_i("memr_dtr_low_cycles", n_dtr_low, 6);
    chk_i("memr_den_cycles", n_den, 4);

    // IOW, no waits
    clear_tallies();
    step(3'd2, 3);
    step(3'd7, 4);
    chk_i("iow_aiowc_cycles", n_aiow, 2);
    chk_i("iow_iowc_cycles", n_iow, 1);
    chk_i("iow_den_cycles", n_den, 1);
    chk_i("iow_dtr_low_cycles", n_dtr_low, 0);

    // Two INTA cycles separated by passive
    clear_tallies();
    step(3'd0, 3);
    step(3'd7, 3);
    step(3'd0, 3);
    step(3'd7, 4);
    chk_i("inta_pulses", n_inta_pulse, 2);
    chk_i("inta_after_ale", n_inta_after_ale, 2);
    chk_i("inta_low_cycles", n_inta, 4);
    chk_i("inta_ale_cycles", n_ale, 2);

    // HALT
    clear_tallies();
    step(3'd3, 3);
    step(3'd7, 4);
    chk_i("halt_ale_cycles", n_ale, 1);
    chk_i("halt_cmd_cycles", n_anycmd, 0);
    chk_i("halt_den_cycles", n_den, 0);

    // MEMW with AEN pulled high in T3
    step(3'd6, 3);
    @(negedge clock);
    #1;
    chk_b("memw_t3_mwtc_on", mwtc_n, 1'b0);
    aen_n = 1'b1;
    #1;
    chk_b("memw_aen_mwtc_off", mwtc_n, 1'b1);
    chk_b("memw_aen_amwc_off", amwc_n, 1'b1);
    @(negedge clock);
    aen_n = 1'b0;
    @(posedge clock);
    #2;
    chk_b("memw_aen_1cyc_off", mwtc_n, 1'b1);
    @(posedge clock);
    #2;
    chk_b("memw_aen_2cyc_on", mwtc_n, 1'b0);
    step(3'd7, 4);

    // Reset during T2 of IOR
    step(3'd1, 2);
    @(posedge clock);
    #2;
    chk_b("ior_t2_on", iorc_n, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_b("ior_async_reset", iorc_n, 1'b1);
    status = 3'd7;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #2;
    chk_i("post_reset_cmds", cmd_vec(), 127);
    chk_b("post_reset_ale", ale, 1'b0);
    chk_b("post_reset_den", den, 1'b0);
    chk_b("post_reset_dtr_n", dtr_n, 1'b1);
    step(3'd7, 3);

    // Randomized traffic
    repeat (3000) begin
      @(negedge clock);
      status  = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
      aen_n   = ($urandom_range(0, 9) == 0);
      cen     = ($urandom_range(0, 9) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step(3'd7, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
